// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with ALU operand selection and hazard detection.
// Build option FWD_EN: MEM/WB operand forwarding with load-use-only stalls; otherwise stall on RAW.
module id_ex_stage #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned RA_W = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            id_valid,
  input  logic [RA_W-1:0] id_rs1,
  input  logic [RA_W-1:0] id_rs2,
  input  logic [RA_W-1:0] id_rd,
  input  logic [XLEN-1:0] id_rs1_data,
  input  logic [XLEN-1:0] id_rs2_data,
  input  logic [XLEN-1:0] id_imm,
  input  logic [XLEN-1:0] id_pc,
  input  logic [3:0]      id_alu_op,
  input  logic            id_src_a_pc,
  input  logic            id_src_b_imm,
  input  logic            id_reg_write,
  input  logic            id_mem_read,
  input  logic            id_mem_write,
  input  logic            flush,
  input  logic [RA_W-1:0] mem_rd,
  input  logic            mem_reg_write,
  input  logic [XLEN-1:0] mem_result,
  input  logic [RA_W-1:0] wb_rd,
  input  logic            wb_reg_write,
  input  logic [XLEN-1:0] wb_result,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output logic [3:0]      alu_opcode,
  output logic [RA_W-1:0] ex_rd,
  output logic            ex_reg_write,
  output logic            ex_mem_read,
  output logic            ex_mem_write,
  output logic            ex_valid,
  output logic [XLEN-1:0] ex_store_data,
  output logic [XLEN-1:0] ex_pc,
  output logic            hazard_stall
);

  logic            r_valid;
  logic [RA_W-1:0] r_rs1;
  logic [RA_W-1:0] r_rs2;
  logic [RA_W-1:0] r_rd;
  logic [XLEN-1:0] r_rs1_val;
  logic [XLEN-1:0] r_rs2_val;
  logic [XLEN-1:0] r_imm;
  logic [XLEN-1:0] r_pc;
  logic [3:0]      r_alu_op;
  logic            r_src_a_pc;
  logic            r_src_b_imm;
  logic            r_reg_write;
  logic            r_mem_read;
  logic            r_mem_write;

  logic            w_hazard;
  logic            w_load;
  logic [XLEN-1:0] w_cap1;
  logic [XLEN-1:0] w_cap2;
  logic [XLEN-1:0] w_fwd1;
  logic [XLEN-1:0] w_fwd2;

  // Register-file read data misses the same-cycle WB write; take it from the WB bus instead
  assign w_cap1 = (wb_reg_write && wb_rd != '0 && wb_rd == id_rs1) ? wb_result : id_rs1_data;
  assign w_cap2 = (wb_reg_write && wb_rd != '0 && wb_rd == id_rs2) ? wb_result : id_rs2_data;

`ifdef FWD_EN
  assign w_hazard = id_valid && !flush && r_mem_read && r_rd != '0 &&
                    (r_rd == id_rs1 || r_rd == id_rs2);

  always_comb begin
    w_fwd1 = r_rs1_val;
    w_fwd2 = r_rs2_val;
    if (mem_reg_write && mem_rd != '0 && mem_rd == r_rs1) w_fwd1 = mem_result;
    else if (wb_reg_write && wb_rd != '0 && wb_rd == r_rs1) w_fwd1 = wb_result;
    if (mem_reg_write && mem_rd != '0 && mem_rd == r_rs2) w_fwd2 = mem_result;
    else if (wb_reg_write && wb_rd != '0 && wb_rd == r_rs2) w_fwd2 = wb_result;
  end
`else
  logic w_rs1_hit;
  logic w_rs2_hit;
  logic w_unused;

  // Without forwarding, any producer still in EX or MEM must drain before the consumer enters
  assign w_rs1_hit = id_rs1 != '0 && ((r_reg_write && r_rd == id_rs1) ||
                                      (mem_reg_write && mem_rd == id_rs1));
  assign w_rs2_hit = id_rs2 != '0 && ((r_reg_write && r_rd == id_rs2) ||
                                      (mem_reg_write && mem_rd == id_rs2));
  assign w_hazard  = id_valid && !flush && (w_rs1_hit || w_rs2_hit);
  assign w_fwd1    = r_rs1_val;
  assign w_fwd2    = r_rs2_val;
  assign w_unused  = ^{r_rs1, r_rs2, mem_result};
`endif

  assign w_load = id_valid && !flush && !w_hazard;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid     <= 1'b0;
      r_rs1       <= '0;
      r_rs2       <= '0;
      r_rd        <= '0;
      r_rs1_val   <= '0;
      r_rs2_val   <= '0;
      r_imm       <= '0;
      r_pc        <= '0;
      r_alu_op    <= '0;
      r_src_a_pc  <= 1'b0;
      r_src_b_imm <= 1'b0;
      r_reg_write <= 1'b0;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
    end else if (w_load) begin
      r_valid     <= 1'b1;
      r_rs1       <= id_rs1;
      r_rs2       <= id_rs2;
      r_rd        <= id_rd;
      r_rs1_val   <= w_cap1;
      r_rs2_val   <= w_cap2;
      r_imm       <= id_imm;
      r_pc        <= id_pc;
      r_alu_op    <= id_alu_op;
      r_src_a_pc  <= id_src_a_pc;
      r_src_b_imm <= id_src_b_imm;
      r_reg_write <= id_reg_write;
      r_mem_read  <= id_mem_read;
      r_mem_write <= id_mem_write;
    end else begin
      // Bubble: all-zero fields decode as ADD with every control deasserted
      r_valid     <= 1'b0;
      r_rs1       <= '0;
      r_rs2       <= '0;
      r_rd        <= '0;
      r_rs1_val   <= '0;
      r_rs2_val   <= '0;
      r_imm       <= '0;
      r_pc        <= '0;
      r_alu_op    <= '0;
      r_src_a_pc  <= 1'b0;
      r_src_b_imm <= 1'b0;
      r_reg_write <= 1'b0;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
    end
  end

  assign alu_a         = r_src_a_pc  ? r_pc  : w_fwd1;
  assign alu_b         = r_src_b_imm ? r_imm : w_fwd2;
  assign ex_store_data = w_fwd2;
  assign alu_opcode    = r_alu_op;
  assign ex_rd         = r_rd;
  assign ex_reg_write  = r_reg_write;
  assign ex_mem_read   = r_mem_read;
  assign ex_mem_write  = r_mem_write;
  assign ex_valid      = r_valid;
  assign ex_pc         = r_pc;
  // Held low through reset even when MEM-stage inputs are still live
  assign hazard_stall  = !rst && w_hazard;

endmodule
